// File: rtl/sc_s2b_counter.sv
// sc_s2b_counter: stochastic-stream to binary converter.
// Counts the ones in a window of 2^WIN_LOG2 valid bitstream samples and
// hands the result to a consumer through a valid/ready register. The
// result register is overwritten when a new window completes, and a
// sticky overrun flag records that a result was lost.

module sc_s2b_counter #(
    parameter int WIN_LOG2 = 8,
    parameter int CONT     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                bit_in,
    input  logic                bit_vld,
    output logic                busy,
    output logic [WIN_LOG2:0]   res_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Sample index of the final sample in a window (all ones).
    localparam logic [WIN_LOG2-1:0] LAST_IDX = {WIN_LOG2{1'b1}};

    state_t              state_q, state_d;
    logic [WIN_LOG2-1:0] ones_q, ones_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [WIN_LOG2:0]   res_data_q, res_data_d;
    logic                res_valid_q, res_valid_d;
    logic                overrun_q, overrun_d;
    logic                finalize;

    // Next-state logic: window control, accumulation and result handoff.
    always_comb begin
        state_d     = state_q;
        ones_d      = ones_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        overrun_d   = overrun_q;
        finalize    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d   = ACCUM;
                    ones_d    = '0;
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                end
            end
            ACCUM: begin
                if (abort) begin
                    // Abort wins over everything, including a completing sample.
                    state_d = IDLE;
                    ones_d  = '0;
                    cnt_d   = '0;
                end else if (bit_vld) begin
                    if (cnt_q == LAST_IDX) begin
                        // Counts restart at zero so a continuous window can take
                        // a sample on the very next cycle.
                        finalize = 1'b1;
                        ones_d   = '0;
                        cnt_d    = '0;
                        state_d  = (CONT != 0) ? ACCUM : IDLE;
                    end else begin
                        ones_d = ones_q + WIN_LOG2'(bit_in);
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finalize) begin
            // One extra bit keeps a full-scale window (all ones) from wrapping.
            res_data_d  = {1'b0, ones_q} + (WIN_LOG2 + 1)'(bit_in);
            res_valid_d = 1'b1;
            if (res_valid_q && !res_ready) begin
                overrun_d = 1'b1;
            end
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // State and result registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ones_q      <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ones_q      <= ones_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign busy      = (state_q == ACCUM);
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sc_s2b_counter.sv
// Testbench for sc_s2b_counter: a single-shot instance and a continuous
// instance, both with 16-sample windows, checked against a window-level model.

module tb_sc_s2b_counter;

    localparam int W = 4;
    localparam int N = 16;

    logic clk;
    logic rst;

    logic start0, abort0, bit_in0, bit_vld0, res_ready0;
    logic busy0, res_valid0, overrun0;
    logic [W:0] res_data0;

    logic start1, abort1, bit_in1, bit_vld1, res_ready1;
    logic busy1, res_valid1, overrun1;
    logic [W:0] res_data1;

    int asserts = 0;
    int fails   = 0;

    typedef struct {
        bit active;
        int ones;
        int cnt;
        int res;
        bit vld;
        bit ovr;
    } model_t;

    model_t m [2];

    sc_s2b_counter #(.WIN_LOG2(W), .CONT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .bit_in(bit_in0), .bit_vld(bit_vld0), .busy(busy0),
        .res_data(res_data0), .res_valid(res_valid0),
        .res_ready(res_ready0), .overrun(overrun0)
    );

    sc_s2b_counter #(.WIN_LOG2(W), .CONT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .bit_in(bit_in1), .bit_vld(bit_vld1), .busy(busy1),
        .res_data(res_data1), .res_valid(res_valid1),
        .res_ready(res_ready1), .overrun(overrun1)
    );

    // Free-running clock, first rising edge at 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) m[i] = '{default: 0};
    endfunction

    // Window-level behaviour: count valid samples, deliver a result after N of them.
    function automatic void model_step(int i, bit cont, bit s, bit a, bit b, bit v, bit r);
        model_t x;
        bit fin;
        x   = m[i];
        fin = 1'b0;
        if (x.active) begin
            if (a) begin
                x.active = 1'b0;
                x.ones   = 0;
                x.cnt    = 0;
            end else if (v) begin
                x.ones = x.ones + int'(b);
                x.cnt  = x.cnt + 1;
                if (x.cnt == N) fin = 1'b1;
            end
        end else if (s && !a) begin
            x.active = 1'b1;
            x.ones   = 0;
            x.cnt    = 0;
            x.ovr    = 1'b0;
        end
        if (fin) begin
            if (x.vld && !r) x.ovr = 1'b1;
            x.res    = x.ones;
            x.vld    = 1'b1;
            x.ones   = 0;
            x.cnt    = 0;
            x.active = cont;
        end else if (x.vld && r) begin
            x.vld = 1'b0;
        end
        m[i] = x;
    endfunction

    // One clock: models step on the rising edge, outputs settle by #1.
    task automatic tick();
        @(posedge clk);
        model_step(0, 1'b0, start0, abort0, bit_in0, bit_vld0, res_ready0);
        model_step(1, 1'b1, start1, abort1, bit_in1, bit_vld1, res_ready1);
        #1;
    endtask

    task automatic drv0(input bit s, input bit a, input bit b, input bit v, input bit r);
        start0 = s; abort0 = a; bit_in0 = b; bit_vld0 = v; res_ready0 = r;
    endtask

    task automatic drv1(input bit s, input bit a, input bit b, input bit v, input bit r);
        start1 = s; abort1 = a; bit_in1 = b; bit_vld1 = v; res_ready1 = r;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        model_reset();
        #2;
        asserts++; if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy0: got %b expected 0", busy0); end
        asserts++; if (res_valid0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid0: got %b expected 0", res_valid0); end
        asserts++; if (res_data0 !== 5'd0) begin fails++; $display("[TB] FAIL reset_data0: got %0d expected 0", res_data0); end
        asserts++; if (overrun0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_ovr0: got %b expected 0", overrun0); end
        asserts++; if (busy1 !== 1'b0 || res_valid1 !== 1'b0 || res_data1 !== 5'd0 || overrun1 !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_dut1: got busy=%b valid=%b data=%0d ovr=%b expected all 0", busy1, res_valid1, res_data1, overrun1);
        end
        #10 rst = 1'b1;
        tick();
        asserts++; if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_idle: got busy %b expected 0", busy0); end
    endtask

    task automatic test_full_ones();
        drv0(1, 0, 0, 0, 0); tick();
        asserts++; if (busy0 !== 1'b1) begin fails++; $display("[TB] FAIL full_busy: got %b expected 1", busy0); end
        for (int k = 0; k < N; k++) begin
            drv0(0, 0, 1, 1, 0); tick();
            if (k < N - 1) begin
                asserts++; if (res_valid0 !== 1'b0) begin fails++; $display("[TB] FAIL full_early_valid k=%0d: got %b expected 0", k, res_valid0); end
            end
        end
        drv0(0, 0, 0, 0, 0);
        asserts++; if (res_valid0 !== 1'b1) begin fails++; $display("[TB] FAIL full_valid: got %b expected 1", res_valid0); end
        asserts++; if (res_data0 !== 5'h10) begin fails++; $display("[TB] FAIL full_data: got %0d expected 16", res_data0); end
        asserts++; if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL full_idle: got busy %b expected 0", busy0); end
        drv0(0, 0, 0, 0, 1); tick();
        drv0(0, 0, 0, 0, 0);
        asserts++; if (res_valid0 !== 1'b0) begin fails++; $display("[TB] FAIL full_consume: got valid %b expected 0", res_valid0); end
        asserts++; if (res_data0 !== 5'h10) begin fails++; $display("[TB] FAIL full_hold: got %0d expected 16", res_data0); end
    endtask

    task automatic test_gaps();
        drv0(1, 0, 0, 0, 0); tick();
        for (int k = 0; k < N; k++) begin
            drv0(0, 0, (k % 2) == 0, 1, 0); tick();
            if (k < N - 1) begin
                asserts++; if (res_valid0 !== 1'b0) begin fails++; $display("[TB] FAIL gaps_early_valid k=%0d: got %b expected 0", k, res_valid0); end
                for (int g = 0; g < 3; g++) begin
                    // A start during the gap must be ignored; bit_in is don't-care.
                    drv0(g == 1, 0, 1'($urandom_range(0, 1)), 0, 0); tick();
                    asserts++; if (res_valid0 !== 1'b0 || busy0 !== 1'b1) begin
                        fails++; $display("[TB] FAIL gaps_gap k=%0d g=%0d: got valid=%b busy=%b expected 0/1", k, g, res_valid0, busy0);
                    end
                end
            end
        end
        drv0(0, 0, 0, 0, 0);
        asserts++; if (res_valid0 !== 1'b1) begin fails++; $display("[TB] FAIL gaps_valid: got %b expected 1", res_valid0); end
        asserts++; if (res_data0 !== 5'd8) begin fails++; $display("[TB] FAIL gaps_data: got %0d expected 8", res_data0); end
    endtask

    task automatic test_abort();
        int sum;
        bit b;
        drv0(1, 0, 0, 0, 0); tick();
        for (int k = 0; k < 7; k++) begin
            drv0(0, 0, 1, 1, 0); tick();
        end
        drv0(1, 1, 1, 1, 0); tick();
        drv0(0, 0, 0, 0, 0);
        asserts++; if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL abort_busy: got %b expected 0", busy0); end
        asserts++; if (res_valid0 !== 1'b1 || res_data0 !== 5'd8) begin
            fails++; $display("[TB] FAIL abort_result: got valid=%b data=%0d expected 1/8", res_valid0, res_data0);
        end
        drv0(0, 0, 0, 0, 1); tick();
        drv0(1, 0, 0, 0, 0); tick();
        sum = 0;
        for (int k = 0; k < N; k++) begin
            b = 1'($urandom_range(0, 1));
            sum += int'(b);
            drv0(0, 0, b, 1, 0); tick();
        end
        drv0(0, 0, 0, 0, 0);
        asserts++; if (res_valid0 !== 1'b1 || res_data0 !== 5'(sum)) begin
            fails++; $display("[TB] FAIL abort_recount: got valid=%b data=%0d expected 1/%0d", res_valid0, res_data0, sum);
        end
        asserts++; if (overrun0 !== 1'b0) begin fails++; $display("[TB] FAIL abort_ovr: got %b expected 0", overrun0); end
    endtask

    task automatic test_back_to_back();
        int sum;
        bit b;
        drv0(1, 0, 0, 0, 0); tick();
        for (int k = 0; k < N; k++) begin
            drv0(0, 0, 1'($urandom_range(0, 1)), 1, 0); tick();
        end
        drv0(1, 0, 0, 0, 0); tick();
        sum = 0;
        for (int k = 0; k < N; k++) begin
            b = (k < 3) ? 1'b1 : 1'($urandom_range(0, 1));
            sum += int'(b);
            drv0(0, 0, b, 1, k == N - 1); tick();
        end
        drv0(0, 0, 0, 0, 0);
        asserts++; if (res_data0 !== 5'(sum)) begin fails++; $display("[TB] FAIL b2b_data: got %0d expected %0d", res_data0, sum); end
        asserts++; if (res_valid0 !== 1'b1) begin fails++; $display("[TB] FAIL b2b_valid: got %b expected 1", res_valid0); end
        asserts++; if (overrun0 !== 1'b0) begin fails++; $display("[TB] FAIL b2b_ovr: got %b expected 0", overrun0); end
    endtask

    task automatic test_reset_mid();
        drv0(1, 0, 0, 0, 0); tick();
        for (int k = 0; k < 5; k++) begin
            drv0(0, 0, 1, 1, 0); tick();
        end
        asserts++; if (busy0 !== 1'b1 || res_valid0 !== 1'b1) begin
            fails++; $display("[TB] FAIL rstmid_pre: got busy=%b valid=%b expected 1/1", busy0, res_valid0);
        end
        #2 rst = 1'b0;
        #1;
        asserts++; if (busy0 !== 1'b0 || res_valid0 !== 1'b0 || res_data0 !== 5'd0 || overrun0 !== 1'b0) begin
            fails++; $display("[TB] FAIL rstmid_async: got busy=%b valid=%b data=%0d ovr=%b expected all 0", busy0, res_valid0, res_data0, overrun0);
        end
        model_reset();
        #3 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drv0(0, 0, 1, 1, 0); tick();
            asserts++; if (busy0 !== 1'b0 || res_valid0 !== 1'b0) begin
                fails++; $display("[TB] FAIL rstmid_wait k=%0d: got busy=%b valid=%b expected 0/0", k, busy0, res_valid0);
            end
        end
        drv0(0, 0, 0, 0, 0);
    endtask

    task automatic test_cont();
        drv1(1, 0, 0, 0, 0); tick();
        for (int k = 0; k < N; k++) begin
            drv1(0, 0, 0, 1, 0); tick();
        end
        asserts++; if (res_valid1 !== 1'b1 || busy1 !== 1'b1 || overrun1 !== 1'b0 || res_data1 !== 5'd0) begin
            fails++; $display("[TB] FAIL cont_first: got valid=%b busy=%b ovr=%b data=%0d expected 1/1/0/0", res_valid1, busy1, overrun1, res_data1);
        end
        for (int k = 0; k < N; k++) begin
            drv1(0, 0, 0, 1, 0); tick();
        end
        asserts++; if (res_valid1 !== 1'b1 || res_data1 !== 5'd0) begin
            fails++; $display("[TB] FAIL cont_second: got valid=%b data=%0d expected 1/0", res_valid1, res_data1);
        end
        asserts++; if (overrun1 !== 1'b1) begin fails++; $display("[TB] FAIL cont_ovr: got %b expected 1", overrun1); end
        drv1(0, 1, 0, 0, 0); tick();
        asserts++; if (busy1 !== 1'b0 || overrun1 !== 1'b1) begin
            fails++; $display("[TB] FAIL cont_abort: got busy=%b ovr=%b expected 0/1", busy1, overrun1);
        end
        drv1(1, 0, 0, 0, 0); tick();
        asserts++; if (overrun1 !== 1'b0 || busy1 !== 1'b1) begin
            fails++; $display("[TB] FAIL cont_restart: got ovr=%b busy=%b expected 0/1", overrun1, busy1);
        end
        // Two full-ones windows back to back: a lost sample would shorten the count.
        for (int k = 0; k < 2 * N; k++) begin
            drv1(0, 0, 1, 1, 1); tick();
            if (k == N - 1) begin
                asserts++; if (res_valid1 !== 1'b1 || res_data1 !== 5'h10) begin
                    fails++; $display("[TB] FAIL cont_w1: got valid=%b data=%0d expected 1/16", res_valid1, res_data1);
                end
            end
        end
        asserts++; if (res_valid1 !== 1'b1 || res_data1 !== 5'h10 || overrun1 !== 1'b0) begin
            fails++; $display("[TB] FAIL cont_w2: got valid=%b data=%0d ovr=%b expected 1/16/0", res_valid1, res_data1, overrun1);
        end
        drv1(0, 1, 0, 0, 1); tick();
        drv1(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            drv0($urandom_range(0, 9) == 0, $urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            drv1($urandom_range(0, 9) == 0, $urandom_range(0, 127) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            tick();
            asserts++; if (busy0 !== m[0].active || res_valid0 !== m[0].vld || overrun0 !== m[0].ovr || res_data0 !== 5'(m[0].res)) begin
                fails++; $display("[TB] FAIL rand0 c=%0d: got busy=%b valid=%b ovr=%b data=%0d expected %b/%b/%b/%0d",
                                  c, busy0, res_valid0, overrun0, res_data0, m[0].active, m[0].vld, m[0].ovr, m[0].res);
            end
            asserts++; if (busy1 !== m[1].active || res_valid1 !== m[1].vld || overrun1 !== m[1].ovr || res_data1 !== 5'(m[1].res)) begin
                fails++; $display("[TB] FAIL rand1 c=%0d: got busy=%b valid=%b ovr=%b data=%0d expected %b/%b/%b/%0d",
                                  c, busy1, res_valid1, overrun1, res_data1, m[1].active, m[1].vld, m[1].ovr, m[1].res);
            end
        end
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_full_ones();
        test_gaps();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_cont();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
